// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command pipeline: opcodes, command layout
// and the fixed divide-by-zero result.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;
    localparam logic [2:0] OP_NOT = 3'd7;

    // Command word as stored in the FIFO: {op, x, y}, 11 bits.
    typedef struct packed {
        logic [2:0] op;
        logic [3:0] x;
        logic [3:0] y;
    } alu_cmd_t;

    localparam int CMD_W = $bits(alu_cmd_t);

    // Result driven for a divide by zero; a defined value, never X.
    localparam logic [7:0] DIV0_RESULT = 8'h0F;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with combinational head read, so the head entry
// can be evaluated and captured downstream on the same edge it is popped.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 11,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     wdata,
    output logic [W-1:0]     rdata,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             do_push, do_pop;

    // Full is checked before any pop, so a full FIFO never accepts a push.
    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign level   = level_q;

    // Storage write; contents need no reset because level gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Pointers wrap naturally (power-of-two depth); level tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/arithmetic_unit.sv
// Combinational 4-bit arithmetic unit with divide-by-zero detection.
module arithmetic_unit
    import alu_pkg::*;
(
    input  logic [2:0] op,
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [7:0] result,
    output logic       overflow,
    output logic       div0
);

    logic [4:0] wide;

    // Evaluate one command; overflow only for add/sub, div0 only for div.
    always_comb begin
        result   = 8'h00;
        overflow = 1'b0;
        div0     = 1'b0;
        wide     = 5'd0;
        case (op)
            OP_ADD: begin
                wide     = 5'(x) + 5'(y);
                result   = {3'b000, wide};
                overflow = wide[4] ^ wide[3];
            end
            OP_SUB: begin
                wide     = 5'(x) - 5'(y);
                result   = {3'b000, wide};
                overflow = wide[4] ^ wide[3];
            end
            OP_MUL: result = 8'(x) * 8'(y);
            OP_DIV: begin
                if (y == 4'd0) begin
                    result = DIV0_RESULT;
                    div0   = 1'b1;
                end else begin
                    result = {4'b0000, x / y};
                end
            end
            OP_AND: result = {4'b0000, x & y};
            OP_OR:  result = {4'b0000, x | y};
            OP_XOR: result = {4'b0000, x ^ y};
            default: result = {4'b0000, ~x};
        endcase
    end

endmodule

// File: rtl/alu_cmd_pipeline.sv
// Handshaked ALU front end: command FIFO, head evaluation, registered
// result stage with valid/ready and a completed-operation counter.
module alu_cmd_pipeline
    import alu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [2:0]                   in_op,
    input  logic [3:0]                   in_x,
    input  logic [3:0]                   in_y,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [7:0]                   out_result,
    output logic                         out_overflow,
    output logic                         out_zero,
    output logic                         out_div0,
    output logic [CNT_W-1:0]             op_count,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    alu_cmd_t   push_cmd, head_cmd;
    logic       fifo_full, fifo_empty, push, pop;
    logic [7:0] au_result;
    logic       au_overflow, au_div0;

    logic       valid_q, valid_d;
    logic [7:0] result_q, result_d;
    logic       ovf_q, ovf_d, zero_q, zero_d, div0_q, div0_d;
    logic [CNT_W-1:0] count_q, count_d;

    assign push_cmd = '{op: in_op, x: in_x, y: in_y};
    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;
    assign pop      = !fifo_empty && (!valid_q || out_ready);

    alu_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (CMD_W),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (push_cmd),
        .rdata (head_cmd),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    arithmetic_unit u_au (
        .op       (head_cmd.op),
        .x        (head_cmd.x),
        .y        (head_cmd.y),
        .result   (au_result),
        .overflow (au_overflow),
        .div0     (au_div0)
    );

    // Output stage next state: load on pop, clear valid after a drained handshake.
    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        div0_d   = div0_q;
        count_d  = count_q;
        if (valid_q && out_ready) begin
            count_d = count_q + CNT_W'(1);
            valid_d = 1'b0;
        end
        if (pop) begin
            valid_d  = 1'b1;
            result_d = au_result;
            ovf_d    = au_overflow;
            zero_d   = (au_result == 8'h00);
            div0_d   = au_div0;
        end
    end

    // Output stage registers; reset drops any held result.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            result_q <= 8'h00;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            div0_q   <= 1'b0;
            count_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            div0_q   <= div0_d;
            count_q  <= count_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_result   = result_q;
    assign out_overflow = ovf_q;
    assign out_zero     = zero_q;
    assign out_div0     = div0_q;
    assign op_count     = count_q;

endmodule

// File: tb/tb_alu_cmd_pipeline.sv
// Self-checking bench for alu_cmd_pipeline with a scoreboard queue.
module tb_alu_cmd_pipeline;

    typedef struct packed {
        logic [7:0] result;
        logic       ovf;
        logic       zero;
        logic       div0;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] in_op = 3'd0;
    logic [3:0] in_x = 4'd0;
    logic [3:0] in_y = 4'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_result;
    logic       out_overflow, out_zero, out_div0;
    logic [7:0] op_count;
    logic [2:0] fifo_level;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic [7:0] cnt_exp = 8'd0;

    alu_cmd_pipeline #(.FIFO_DEPTH(4), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_x         (in_x),
        .in_y         (in_y),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_overflow (out_overflow),
        .out_zero     (out_zero),
        .out_div0     (out_div0),
        .op_count     (op_count),
        .fifo_level   (fifo_level)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [2:0] op, input logic [3:0] x, input logic [3:0] y);
        exp_t e;
        int   s;
        e = '0;
        case (op)
            3'd0: begin s = int'(x) + int'(y); e.result = 8'(s); e.ovf = s[4] ^ s[3]; end
            3'd1: begin s = (int'(x) - int'(y)) & 31; e.result = 8'(s); e.ovf = s[4] ^ s[3]; end
            3'd2: e.result = 8'(int'(x) * int'(y));
            3'd3: begin
                if (y == 0) begin e.result = 8'h0F; e.div0 = 1'b1; end
                else e.result = 8'(int'(x) / int'(y));
            end
            3'd4: e.result = {4'h0, x & y};
            3'd5: e.result = {4'h0, x | y};
            3'd6: e.result = {4'h0, x ^ y};
            default: e.result = {4'h0, 4'hF - x};
        endcase
        e.zero = (e.result == 8'h00);
        return e;
    endfunction

    // Drive one command from a negedge; returns at the negedge after acceptance.
    task automatic send_cmd(input logic [2:0] op, input logic [3:0] x, input logic [3:0] y);
        int n = 0;
        in_op = op; in_x = x; in_y = y; in_valid = 1'b1;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_timeout in_ready=%b required 1", in_ready);
        end else begin
            sb.push_back(model(op, x, y));
        end
        @(negedge clk);
        in_valid = 1'b0;
        $display("send op=%0d x=%h y=%h", op, x, y);
    endtask

    // Wait for a result, compare against the scoreboard head, then check op_count.
    task automatic expect_out(input string name);
        int   n = 0;
        exp_t e;
        out_ready = 1'b1;
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout out_valid=%b required 1", name, out_valid);
        end else if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s_unexpected result=%h with empty scoreboard", name, out_result);
        end else begin
            e = sb.pop_front();
            if ({out_result, out_overflow, out_zero, out_div0} !== e) begin
                errors++;
                $display("FAIL %s result=%h ovf=%b zero=%b div0=%b required %h %b %b %b",
                         name, out_result, out_overflow, out_zero, out_div0,
                         e.result, e.ovf, e.zero, e.div0);
            end else begin
                $display("recv %s result=%h ovf=%b zero=%b div0=%b", name,
                         out_result, out_overflow, out_zero, out_div0);
            end
            cnt_exp++;
        end
        @(negedge clk);
        checks++;
        if (op_count !== cnt_exp) begin
            errors++;
            $display("FAIL %s_count op_count=%0d required %0d", name, op_count, cnt_exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({out_valid, fifo_level, op_count, out_result, out_overflow, out_zero, out_div0} !== '0
            || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state valid=%b level=%0d cnt=%0d res=%h flags=%b%b%b in_ready=%b required all 0, in_ready 1",
                     out_valid, fifo_level, op_count, out_result, out_overflow, out_zero, out_div0, in_ready);
        end
        sb.delete();
        cnt_exp = 8'd0;
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        send_cmd(3'd0, 4'h9, 4'h7);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_no_bypass out_valid=%b required 0", out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL add_latency out_valid=%b required 1", out_valid);
        end
        expect_out("add");
    endtask

    task automatic test_ops();
        send_cmd(3'd1, 4'h3, 4'h5); expect_out("sub");
        send_cmd(3'd2, 4'hF, 4'hF); expect_out("mul");
        send_cmd(3'd3, 4'h9, 4'h0); expect_out("div0");
        send_cmd(3'd3, 4'h9, 4'h2); expect_out("div");
        send_cmd(3'd4, 4'hA, 4'h5); expect_out("and");
        send_cmd(3'd7, 4'hF, 4'h3); expect_out("not");
        send_cmd(3'd5, 4'hA, 4'h4); expect_out("or");
        send_cmd(3'd6, 4'hC, 4'hA); expect_out("xor");
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL out_clear out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [2:0] ops [6] = '{3'd0, 3'd2, 3'd1, 3'd6, 3'd3, 3'd5};
        logic [3:0] xs  [6] = '{4'h1, 4'h3, 4'h8, 4'hF, 4'hE, 4'h2};
        logic [3:0] ys  [6] = '{4'h2, 4'h4, 4'h1, 4'h0, 4'h3, 4'h9};
        int   idx = 0;
        bit   have_snap = 0;
        logic [10:0] snap = '0;
        exp_t e;
        out_ready = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (in_ready && idx < 6) begin
                in_op = ops[idx]; in_x = xs[idx]; in_y = ys[idx]; in_valid = 1'b1;
                sb.push_back(model(ops[idx], xs[idx], ys[idx]));
                idx++;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (out_valid) begin
                if (!have_snap) begin
                    snap = {out_result, out_overflow, out_zero, out_div0};
                    have_snap = 1;
                end else begin
                    checks++;
                    if ({out_result, out_overflow, out_zero, out_div0} !== snap) begin
                        errors++;
                        $display("FAIL hold_stable cycle=%0d out=%h required %h", c,
                                 {out_result, out_overflow, out_zero, out_div0}, snap);
                    end
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (idx != 5 || in_ready !== 1'b0 || fifo_level !== 3'd4) begin
            errors++;
            $display("FAIL full_state accepted=%0d in_ready=%b level=%0d required 5 0 4",
                     idx, in_ready, fifo_level);
        end
        sb.pop_back();
        sb.push_back(model(ops[4], xs[4], ys[4]));
        // Release: five results on consecutive cycles, in order.
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            e = sb.pop_front();
            checks++;
            if (out_valid !== 1'b1 || {out_result, out_overflow, out_zero, out_div0} !== e) begin
                errors++;
                $display("FAIL drain_%0d valid=%b out=%h required 1 %h", k, out_valid,
                         {out_result, out_overflow, out_zero, out_div0}, e);
            end else begin
                $display("recv drain_%0d result=%h", k, out_result);
            end
            cnt_exp++;
            @(negedge clk);
        end
        checks++;
        if (op_count !== cnt_exp || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_done op_count=%0d valid=%b required %0d 0", op_count, out_valid, cnt_exp);
        end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        send_cmd(3'd0, 4'h1, 4'h1);
        send_cmd(3'd2, 4'h2, 4'h3);
        send_cmd(3'd6, 4'h5, 4'h6);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        cnt_exp = 8'd0;
        checks++;
        if (out_valid !== 1'b0 || fifo_level !== 3'd0 || op_count !== 8'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset valid=%b level=%0d cnt=%0d in_ready=%b required 0 0 0 1",
                     out_valid, fifo_level, op_count, in_ready);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL stale_result cycle=%0d out_valid=%b required 0", k, out_valid);
            end
        end
        send_cmd(3'd1, 4'hA, 4'h3);
        expect_out("post_reset");
    endtask

    task automatic test_count_wrap();
        logic [2:0] op;
        logic [3:0] x, y;
        for (int i = 0; i < 256; i++) begin
            op = 3'($urandom_range(0, 7));
            x  = 4'($urandom_range(0, 15));
            y  = 4'($urandom_range(0, 15));
            send_cmd(op, x, y);
            expect_out("rand");
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_ops();
        test_backpressure();
        test_mid_reset();
        test_count_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
